input_unpacker: RTL

- AXI-Stream slave: accepts 512-bit activation beats from the DMA/stream fabric.
- Unpacks each beat into NUM_LANES parallel 8-bit channel values for the compute engines, one slice per cycle.
- Receive-side counterpart of the output packer; uses the same byte ordering (byte i at bits [8i+7:8i]).
- Full-throughput skid buffering on the input so s_axis_tready is driven from a register.

---
 rtl/yolo_stream_pkg.sv | 19 +
 rtl/input_unpacker_if.sv | 32 +++
 rtl/axis_skid_buffer.sv | 75 +++++++
 rtl/input_unpacker.sv | 105 ++++++++++
 4 files changed

// File: rtl/yolo_stream_pkg.sv
// Shared stream constants, lane byte type and slice-count helpers for the input unpacker.
package yolo_stream_pkg;

  localparam int unsigned AxisWidthDefault = 512;
  localparam int unsigned ByteWidth        = 8;

  typedef logic [ByteWidth-1:0] pixel_byte_t;

  // Output transfers needed to present one stream beat across the lanes.
  function automatic int unsigned num_slices(int unsigned axis_width, int unsigned lanes);
    return axis_width / (ByteWidth * lanes);
  endfunction

  // Index width for a count, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_unpacker_if.sv
// Stream-in / lanes-out bundle for the input unpacker; slave is the unpacker's view.
interface input_unpacker_if #(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned AXIS_WIDTH = yolo_stream_pkg::AxisWidthDefault
);
  import yolo_stream_pkg::*;

  localparam int unsigned SLICES  = num_slices(AXIS_WIDTH, NUM_LANES);
  localparam int unsigned SLICE_W = idx_width(SLICES);

  logic [AXIS_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  s_axis_tlast;

  pixel_byte_t           pixel_channels [NUM_LANES];
  logic                  valid_out;
  logic                  ready_in;
  logic                  last_out;
  logic [SLICE_W-1:0]    slice_idx;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, ready_in,
    output s_axis_tready, pixel_channels, valid_out, last_out, slice_idx
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, ready_in,
    input  s_axis_tready, pixel_channels, valid_out, last_out, slice_idx
  );

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry holding/skid register pair with a registered ready.
// The downstream side drains the holding entry via out_consume_i.
module axis_skid_buffer #(
  parameter int unsigned DataW = 513
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DataW-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [DataW-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_consume_i
);

  logic [DataW-1:0] h_data_q, h_data_d, k_data_q, k_data_d;
  logic             h_valid_q, h_valid_d, k_valid_q, k_valid_d;
  logic             ready_q;
  logic             accept;

  // ready_q resets high so the port rises on the first cycle out of reset; rst masks it meanwhile.
  assign in_ready_o  = ready_q & ~rst;
  assign accept      = in_valid_i & in_ready_o;
  assign out_data_o  = h_data_q;
  assign out_valid_o = h_valid_q;

  // Route each accepted beat to holding or skid; skid refills holding when it drains.
  always_comb begin
    h_data_d  = h_data_q;
    h_valid_d = h_valid_q;
    k_data_d  = k_data_q;
    k_valid_d = k_valid_q;
    if (out_consume_i) begin
      if (k_valid_q) begin
        // ready was low, so no beat can be accepted this cycle
        h_data_d  = k_data_q;
        h_valid_d = 1'b1;
        k_valid_d = 1'b0;
      end else if (accept) begin
        h_data_d  = in_data_i;
        h_valid_d = 1'b1;
      end else begin
        h_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!h_valid_q) begin
        h_data_d  = in_data_i;
        h_valid_d = 1'b1;
      end else begin
        k_data_d  = in_data_i;
        k_valid_d = 1'b1;
      end
    end
  end

  // Valid flags and ready register; reset discards any buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      h_valid_q <= h_valid_d;
      k_valid_q <= k_valid_d;
      ready_q   <= ~k_valid_d;
    end
  end

  // Payload registers need no reset; they are qualified by the valid flags.
  always_ff @(posedge clk) begin
    h_data_q <= h_data_d;
    k_data_q <= k_data_d;
  end

endmodule

// File: rtl/input_unpacker.sv
// Input unpacker: accepts wide stream beats and presents them NUM_LANES bytes per cycle,
// lane i of slice c carrying beat byte c*NUM_LANES+i.
// Optional INPUT_UNPACKER_PERF_CNT_EN adds saturating beat/stall/starve counters.
module input_unpacker
  import yolo_stream_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned AXIS_WIDTH = AxisWidthDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input_unpacker_if.slave         bus
`ifdef INPUT_UNPACKER_PERF_CNT_EN
  ,
  output logic [31:0]             beat_cnt,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             starve_cnt
`endif
);

  localparam int unsigned SLICES  = num_slices(AXIS_WIDTH, NUM_LANES);
  localparam int unsigned SliceW  = idx_width(SLICES);
  localparam logic [SliceW-1:0] LastSlice = SliceW'(SLICES - 1);

  if ((AXIS_WIDTH % (ByteWidth * NUM_LANES)) != 0) begin : g_bad_width
    $error("input_unpacker: AXIS_WIDTH must be a multiple of 8*NUM_LANES");
  end

  logic [AXIS_WIDTH:0]   skid_out;
  logic [AXIS_WIDTH-1:0] h_data;
  logic                  h_last;
  logic                  h_valid;
  logic                  xfer;
  logic                  consume;
  logic [SliceW-1:0]     cnt_q, cnt_d;

  assign xfer    = h_valid & bus.ready_in;
  assign consume = xfer & (cnt_q == LastSlice);

  axis_skid_buffer #(
    .DataW (AXIS_WIDTH + 1)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .in_data_i     ({bus.s_axis_tlast, bus.s_axis_tdata}),
    .in_valid_i    (bus.s_axis_tvalid),
    .in_ready_o    (bus.s_axis_tready),
    .out_data_o    (skid_out),
    .out_valid_o   (h_valid),
    .out_consume_i (consume)
  );

  assign h_last = skid_out[AXIS_WIDTH];
  assign h_data = skid_out[AXIS_WIDTH-1:0];

  // Slice counter advances on each output transfer and wraps after the final slice.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) begin
      cnt_d = (cnt_q == LastSlice) ? '0 : cnt_q + 1'b1;
    end
  end

  // Slice counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Lane mux: select the current slice of the holding beat.
  always_comb begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      bus.pixel_channels[i] = h_data[(32'(cnt_q) * NUM_LANES + i) * ByteWidth +: ByteWidth];
    end
  end

  assign bus.valid_out = h_valid;
  assign bus.slice_idx = cnt_q;
  assign bus.last_out  = h_valid & h_last & (cnt_q == LastSlice);

`ifdef INPUT_UNPACKER_PERF_CNT_EN
  logic beat_ev, stall_ev, starve_ev;

  assign beat_ev   = bus.s_axis_tvalid & bus.s_axis_tready;
  assign stall_ev  = h_valid & ~bus.ready_in;
  assign starve_ev = ~h_valid & bus.ready_in;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= '0;
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (beat_ev && (beat_cnt != '1)) beat_cnt <= beat_cnt + 1'b1;
      if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (starve_ev && (starve_cnt != '1)) starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule
